// File: rtl/hazard_pkg.sv
// Shared encodings for the forwarding / interlock unit.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_LU  = 2'b11;

    localparam int unsigned LD_CNT_W = 3;
    localparam int unsigned LU_CNT_W = 3;

    typedef enum logic {
        RUN      = 1'b0,
        LD_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard and outstanding-op counter for the long-latency unit.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LU_MAX_OUT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_long_start,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic                   flush_ex,
    input  logic                   lu_done,
    input  logic [REG_AW-1:0]      lu_rd,
    output logic [(2**REG_AW)-1:0] busy,
    output logic                   lu_full_c
);

    localparam int unsigned NREG = 2**REG_AW;

    logic [NREG-1:0]     busy_q;
    logic [NREG-1:0]     set_vec;
    logic [NREG-1:0]     clr_vec;
    logic [LU_CNT_W-1:0] lu_out_q;
    logic                accept;
    logic                inc;
    logic                dec;

    // A stalled EX slot is being bubbled, so its launch is not accepted.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        accept  = ex_long_start & ~flush_ex;
        if (accept && (ex_rd != '0)) set_vec[ex_rd] = 1'b1;
        if (lu_done) clr_vec[lu_rd] = 1'b1;
        inc = accept && (lu_out_q < LU_CNT_W'(LU_MAX_OUT));
        dec = lu_done && (lu_out_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            lu_out_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_vec) | set_vec;
            if (inc && !dec) begin
                lu_out_q <= lu_out_q + LU_CNT_W'(1);
            end else if (dec && !accept) begin
                lu_out_q <= lu_out_q - LU_CNT_W'(1);
            end
        end
    end

    assign busy      = busy_q;
    assign lu_full_c = (lu_out_q == LU_CNT_W'(LU_MAX_OUT)) & ~lu_done;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding selects plus load-use / long-latency interlock and stall counter.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned LU_MAX_OUT = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]          id_rs_used,
    input  logic                        id_long,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic                        ex_reg_write,
    input  logic                        ex_mem_read,
    input  logic                        ex_long_start,
    input  logic [REG_AW-1:0]           mem_rd,
    input  logic                        mem_reg_write,
    input  logic [REG_AW-1:0]           wb_rd,
    input  logic                        wb_reg_write,
    input  logic                        lu_done,
    input  logic [REG_AW-1:0]           lu_rd,
    output logic [NUM_SRC*2-1:0]        fwd_sel,
    output logic                        stall_if,
    output logic                        stall_id,
    output logic                        flush_ex,
    output logic [(2**REG_AW)-1:0]      busy_mask,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int unsigned NREG     = 2**REG_AW;
    localparam int unsigned LD_INIT  = (LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0;
    localparam logic        LD_MULTI = (LOAD_LAT > 1);

    hz_state_e           state_q, state_d;
    logic [LD_CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_SRC*2-1:0] sel_raw;
    logic [NUM_SRC-1:0]  ld_hit;
    logic [NUM_SRC-1:0]  lu_hit;
    logic [NREG-1:0]     busy_q;
    logic                lu_full_c;
    logic                hz_ld, hz_lu, hz_full, stall_c;
    logic [CNT_W-1:0]    stall_cnt_q;

    // Per-channel forwarding priority and ID-stage hazard compares.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] src;
        logic [REG_AW-1:0] ids;
        logic [1:0]        sel;

        assign src = ex_rs[i*REG_AW +: REG_AW];
        assign ids = id_rs[i*REG_AW +: REG_AW];

        always_comb begin
            sel = FWD_RF;
            if (src != '0) begin
                if (mem_reg_write && (mem_rd == src))    sel = FWD_MEM;
                else if (wb_reg_write && (wb_rd == src)) sel = FWD_WB;
                else if (lu_done && (lu_rd == src))      sel = FWD_LU;
            end
        end

        assign sel_raw[2*i +: 2] = sel;
        assign ld_hit[i] = id_rs_used[i] && (ids == ex_rd);
        assign lu_hit[i] = id_rs_used[i] && (ids != '0) && busy_q[ids]
                           && !(lu_done && (lu_rd == ids));
    end

    hazard_scoreboard #(
        .REG_AW     (REG_AW),
        .LU_MAX_OUT (LU_MAX_OUT)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .ex_long_start (ex_long_start),
        .ex_rd         (ex_rd),
        .flush_ex      (stall_c),
        .lu_done       (lu_done),
        .lu_rd         (lu_rd),
        .busy          (busy_q),
        .lu_full_c     (lu_full_c)
    );

    assign hz_ld   = ex_mem_read & ex_reg_write & (ex_rd != '0) & (|ld_hit);
    assign hz_lu   = |lu_hit;
    assign hz_full = id_long & lu_full_c;
    assign stall_c = (state_q == LD_STALL) | hz_ld | hz_lu | hz_full;

    // The hazard cycle itself is the first bubble; LD_STALL covers the remaining LOAD_LAT-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (hz_ld && LD_MULTI) begin
                    state_d = LD_STALL;
                    cnt_d   = LD_CNT_W'(LD_INIT);
                end
            end
            LD_STALL: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - LD_CNT_W'(1);
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fwd_sel   = rst ? '0 : sel_raw;
    assign stall_if  = stall_c & ~rst;
    assign stall_id  = stall_c & ~rst;
    assign flush_ex  = stall_c & ~rst;
    assign busy_mask = rst ? '0 : busy_q;
    assign stall_cnt = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (LOAD_LAT=2, LU_MAX_OUT=2, NUM_SRC=2).
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic        id_long;
    logic [9:0]  ex_rs;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_long_start;
    logic [4:0]  mem_rd, wb_rd, lu_rd;
    logic        mem_reg_write, wb_reg_write, lu_done;
    logic [3:0]  fwd_sel;
    logic        stall_if, stall_id, flush_ex;
    logic [31:0] busy_mask;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .REG_AW(5), .NUM_SRC(2), .LOAD_LAT(2), .LU_MAX_OUT(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_long(id_long),
        .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_long_start(ex_long_start), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .lu_done(lu_done), .lu_rd(lu_rd),
        .fwd_sel(fwd_sel), .stall_if(stall_if), .stall_id(stall_id), .flush_ex(flush_ex),
        .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [4:0] rs0, rs1, mrd;
        logic       mwe;
        logic [4:0] wrd;
        logic       wwe, lud;
        logic [4:0] lurd;
        logic [3:0] sel;
    } fvec_t;

    typedef struct {
        logic [3:0]  sel;
        logic        stl;
        logic [31:0] busy;
        logic [15:0] cnt;
        logic [3:0]  en;   // [0] sel, [1] stall, [2] busy, [3] cnt
    } exp_t;

    exp_t  expq[$];
    fvec_t vecs[8];

    localparam logic [3:0] EN_SEL = 4'b0001;
    localparam logic [3:0] EN_STL = 4'b0010;
    localparam logic [3:0] EN_BSY = 4'b0100;
    localparam logic [3:0] EN_CNT = 4'b1000;

    task automatic clr_in();
        id_rs = '0; id_rs_used = '0; id_long = 1'b0; ex_rs = '0; ex_rd = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_long_start = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
        lu_done = 1'b0; lu_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [3:0] sel, input logic stl, input logic [31:0] busy,
                              input logic [15:0] cnt, input logic [3:0] en);
        exp_t e;
        e.sel = sel; e.stl = stl; e.busy = busy; e.cnt = cnt; e.en = en;
        expq.push_back(e);
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        @(negedge clk);
        if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard queue empty", nm);
            return;
        end
        e = expq.pop_front();
        if (e.en[0]) begin
            total++;
            if (fwd_sel !== e.sel) begin
                bad++;
                $display("FAIL %s fwd_sel: got %b want %b", nm, fwd_sel, e.sel);
            end
        end
        if (e.en[1]) begin
            total++;
            if ({stall_if, stall_id, flush_ex} !== {3{e.stl}}) begin
                bad++;
                $display("FAIL %s stall: got %b%b%b want %b", nm, stall_if, stall_id, flush_ex, e.stl);
            end
        end
        if (e.en[2]) begin
            total++;
            if (busy_mask !== e.busy) begin
                bad++;
                $display("FAIL %s busy_mask: got %h want %h", nm, busy_mask, e.busy);
            end
        end
        if (e.en[3]) begin
            total++;
            if (stall_cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s stall_cnt: got %0d want %0d", nm, stall_cnt, e.cnt);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        //           rs0    rs1    mrd    mwe   wrd    wwe   lud   lurd   sel
        vecs[0] = '{5'd5,  5'd0,  5'd5,  1'b1, 5'd5,  1'b1, 1'b0, 5'd0,  4'b0010};
        vecs[1] = '{5'd3,  5'd0,  5'd0,  1'b1, 5'd3,  1'b1, 1'b0, 5'd0,  4'b0001};
        vecs[2] = '{5'd4,  5'd7,  5'd1,  1'b1, 5'd2,  1'b1, 1'b1, 5'd7,  4'b1100};
        vecs[3] = '{5'd6,  5'd6,  5'd6,  1'b0, 5'd6,  1'b1, 1'b0, 5'd0,  4'b0101};
        vecs[4] = '{5'd8,  5'd9,  5'd9,  1'b1, 5'd8,  1'b0, 1'b1, 5'd8,  4'b1011};
        vecs[5] = '{5'd31, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 1'b1, 5'd31, 4'b1010};
        vecs[6] = '{5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b1, 5'd0,  4'b0000};
        vecs[7] = '{5'd12, 5'd13, 5'd12, 1'b0, 5'd13, 1'b0, 1'b0, 5'd12, 4'b0000};

        // Reset: outputs forced to zero even with matching forwarding inputs.
        clr_in();
        rst = 1'b1;
        ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_reg_write = 1'b1;
        expect_out(4'b0000, 1'b0, 32'h0, 16'd0, EN_SEL | EN_STL | EN_BSY | EN_CNT);
        check_out("reset_hold");
        tick();
        expect_out(4'b0000, 1'b0, 32'h0, 16'd0, EN_SEL | EN_STL | EN_BSY | EN_CNT);
        check_out("reset_after_edge");
        tick();
        rst = 1'b0;
        clr_in();

        // Combinational forwarding priority table.
        for (int i = 0; i < 8; i++) begin
            tick();
            clr_in();
            ex_rs = {vecs[i].rs1, vecs[i].rs0};
            mem_rd = vecs[i].mrd; mem_reg_write = vecs[i].mwe;
            wb_rd = vecs[i].wrd;  wb_reg_write = vecs[i].wwe;
            lu_done = vecs[i].lud; lu_rd = vecs[i].lurd;
            expect_out(vecs[i].sel, 1'b0, 32'h0, 16'd0, EN_SEL | EN_STL);
            check_out($sformatf("fwd_vec%0d", i));
        end

        // Load-use with LOAD_LAT=2: exactly two stall cycles.
        tick(); clr_in();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd3;
        id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
        expect_out(4'b0, 1'b1, 32'h0, 16'd0, EN_STL | EN_CNT);
        check_out("ld_cycle0");
        tick();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
        expect_out(4'b0, 1'b1, 32'h0, 16'd1, EN_STL | EN_CNT);
        check_out("ld_cycle1");
        tick();
        expect_out(4'b0, 1'b0, 32'h0, 16'd2, EN_STL | EN_CNT);
        check_out("ld_release");

        // Scoreboard: consumer waits for LU result, released in the lu_done cycle.
        tick(); clr_in();
        ex_long_start = 1'b1; ex_rd = 5'd9; ex_reg_write = 1'b1;
        expect_out(4'b0, 1'b0, 32'h0, 16'd2, EN_STL | EN_BSY);
        check_out("lu_launch9");
        tick(); clr_in();
        id_rs = {5'd9, 5'd0}; id_rs_used = 2'b10;
        expect_out(4'b0, 1'b1, 32'h1 << 9, 16'd2, EN_STL | EN_BSY);
        check_out("lu_wait1");
        tick();
        expect_out(4'b0, 1'b1, 32'h1 << 9, 16'd3, EN_STL | EN_CNT);
        check_out("lu_wait2");
        tick();
        lu_done = 1'b1; lu_rd = 5'd9;
        expect_out(4'b0, 1'b0, 32'h1 << 9, 16'd4, EN_STL | EN_BSY | EN_CNT);
        check_out("lu_done_release");
        tick();
        lu_done = 1'b0; lu_rd = 5'd0;
        expect_out(4'b0, 1'b0, 32'h0, 16'd4, EN_STL | EN_BSY | EN_CNT);
        check_out("lu_busy_cleared");

        // Outstanding limit: full stall, bypassed by same-cycle lu_done.
        tick(); clr_in();
        ex_long_start = 1'b1; ex_rd = 5'd10; ex_reg_write = 1'b1;
        expect_out(4'b0, 1'b0, 32'h0, 16'd4, EN_STL);
        check_out("full_launch10");
        tick();
        ex_rd = 5'd11;
        expect_out(4'b0, 1'b0, 32'h1 << 10, 16'd4, EN_STL | EN_BSY);
        check_out("full_launch11");
        tick(); clr_in();
        id_long = 1'b1;
        expect_out(4'b0, 1'b1, (32'h1 << 10) | (32'h1 << 11), 16'd4, EN_STL | EN_BSY);
        check_out("full_stall");
        tick();
        lu_done = 1'b1; lu_rd = 5'd10;
        ex_long_start = 1'b1; ex_rd = 5'd12; ex_reg_write = 1'b1;
        expect_out(4'b0, 1'b0, 32'h0, 16'd5, EN_STL | EN_CNT);
        check_out("full_done_bypass");
        tick(); clr_in();
        id_long = 1'b1;
        expect_out(4'b0, 1'b1, (32'h1 << 11) | (32'h1 << 12), 16'd5, EN_STL | EN_BSY | EN_CNT);
        check_out("full_again");

        // Drain, set busy[4], enter LD_STALL, then reset in the middle.
        tick(); clr_in();
        lu_done = 1'b1; lu_rd = 5'd11;
        expect_out(4'b0, 1'b0, 32'h0, 16'd6, EN_STL | EN_CNT);
        check_out("drain11");
        tick();
        lu_rd = 5'd12;
        expect_out(4'b0, 1'b0, 32'h1 << 12, 16'd6, EN_STL | EN_BSY);
        check_out("drain12");
        tick(); clr_in();
        ex_long_start = 1'b1; ex_rd = 5'd4; ex_reg_write = 1'b1;
        expect_out(4'b0, 1'b0, 32'h0, 16'd6, EN_STL | EN_BSY);
        check_out("launch4");
        tick(); clr_in();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd3;
        id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
        expect_out(4'b0, 1'b1, 32'h1 << 4, 16'd6, EN_STL | EN_BSY | EN_CNT);
        check_out("ld2_cycle0");
        tick();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
        rst = 1'b1;
        ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_reg_write = 1'b1;
        expect_out(4'b0000, 1'b0, 32'h0, 16'd0, EN_SEL | EN_STL | EN_BSY | EN_CNT);
        check_out("rst_mid_stall");
        tick();
        rst = 1'b0;
        clr_in();
        expect_out(4'b0000, 1'b0, 32'h0, 16'd0, EN_SEL | EN_STL | EN_BSY | EN_CNT);
        check_out("post_reset_run");

        if (expq.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover: %0d expectations unchecked", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
